// File: rtl/rl_iteration_sequencer_if.sv
// Interface bundling the control and status signals between the RL iteration
// sequencer and its surroundings: the PE array, the ring, the force caches,
// broadcast_controller and motion_update_control.
//
// Signals (slave = sequencer side):
//   start, num_iterations, drain_cycles  run launch and its configuration
//   ref_wb_issued                        per-PE writeback-issued pulses
//   goto_next_ref                        broadcast_controller moved on; abort drain
//   all_reading_done, force_path_idle    idle conditions for motion update
//   mu_done                              motion update finished
//   iter_start, all_ref_wb_issued,
//   interconnect_empty,
//   motion_update_start                  sequencing outputs
//   iter_count, busy, done, timeout_err  status
interface rl_iteration_sequencer_if #(
  parameter int NUM_CELLS   = 64,
  parameter int ITER_WIDTH  = 16,
  parameter int DRAIN_WIDTH = $clog2(NUM_CELLS) + 1
);
  logic                   start;
  logic [ITER_WIDTH-1:0]  num_iterations;
  logic [DRAIN_WIDTH-1:0] drain_cycles;
  logic [NUM_CELLS-1:0]   ref_wb_issued;
  logic                   goto_next_ref;
  logic                   all_reading_done;
  logic                   force_path_idle;
  logic                   mu_done;

  logic                   iter_start;
  logic                   all_ref_wb_issued;
  logic                   interconnect_empty;
  logic                   motion_update_start;
  logic [ITER_WIDTH-1:0]  iter_count;
  logic                   busy;
  logic                   done;
  logic                   timeout_err;

  // Environment side: drives requests and idle indications, observes status.
  modport master (
    output start, num_iterations, drain_cycles, ref_wb_issued,
           goto_next_ref, all_reading_done, force_path_idle, mu_done,
    input  iter_start, all_ref_wb_issued, interconnect_empty,
           motion_update_start, iter_count, busy, done, timeout_err
  );

  // Sequencer side.
  modport slave (
    input  start, num_iterations, drain_cycles, ref_wb_issued,
           goto_next_ref, all_reading_done, force_path_idle, mu_done,
    output iter_start, all_ref_wb_issued, interconnect_empty,
           motion_update_start, iter_count, busy, done, timeout_err
  );
endinterface

// File: rtl/rl_iteration_sequencer.sv
// RL iteration sequencer: runs N force / motion-update iterations.
// Each iteration collects a ref_wb_issued pulse from every PE, waits a
// programmable ring drain window, then fires motion_update_start once reading,
// writeback and the interconnect are idle. After mu_done it either starts the
// next iteration or finishes. A watchdog flags a stall when no state change
// has happened for TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-low reset
//   bus   rl_iteration_sequencer_if.slave (see the interface for signal list)
module rl_iteration_sequencer #(
  parameter int NUM_CELLS      = 64,
  parameter int ITER_WIDTH     = 16,
  parameter int DRAIN_WIDTH    = $clog2(NUM_CELLS) + 1,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input logic                     clk,
  input logic                     rst,
  rl_iteration_sequencer_if.slave bus
);

  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_WIDTH-1:0]    WD_LIMIT      = WD_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [DRAIN_WIDTH-1:0] DEFAULT_DRAIN = DRAIN_WIDTH'(NUM_CELLS);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DRAIN,
    MU_WAIT,
    DONE
  } state_t;

  state_t                 state;
  logic [NUM_CELLS-1:0]   mask;
  logic [DRAIN_WIDTH-1:0] drain_cnt;
  logic [DRAIN_WIDTH-1:0] drain_len;
  logic [ITER_WIDTH-1:0]  target;
  logic [ITER_WIDTH-1:0]  iter_count;
  logic [WD_WIDTH-1:0]    wd_cnt;
  logic                   iter_start;
  logic                   all_ref;
  logic                   timeout_err;

  logic                   drain_end;
  logic                   mu_fire;
  logic [ITER_WIDTH-1:0]  iter_next;

  // End of the drain window; motion update may only start here and only if
  // every consumer of the ring has gone quiet.
  assign drain_end = (state == DRAIN) && (drain_cnt == drain_len);
  assign mu_fire   = drain_end && bus.all_reading_done && bus.force_path_idle;
  assign iter_next = iter_count + ITER_WIDTH'(1);

  // Every branch that changes state also clears wd_cnt, so the watchdog only
  // counts cycles spent in a single state. Later assignments in the case
  // statement override the watchdog defaults written above it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mask        <= '0;
      drain_cnt   <= '0;
      drain_len   <= '0;
      target      <= '0;
      iter_count  <= '0;
      wd_cnt      <= '0;
      iter_start  <= 1'b0;
      all_ref     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      iter_start <= 1'b0;

      if (state == IDLE || state == DONE) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WD_LIMIT) begin
        timeout_err <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + WD_WIDTH'(1);
      end

      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            target      <= (bus.num_iterations == '0) ? ITER_WIDTH'(1) : bus.num_iterations;
            drain_len   <= (bus.drain_cycles == '0) ? DEFAULT_DRAIN : bus.drain_cycles;
            iter_count  <= '0;
            mask        <= '0;
            timeout_err <= 1'b0;
            iter_start  <= 1'b1;
            wd_cnt      <= '0;
            state       <= COLLECT;
          end
        end

        // Pulses arriving while the full mask is being acted on are dropped;
        // the mask is already complete at that point.
        COLLECT: begin
          if (&mask) begin
            drain_cnt <= '0;
            all_ref   <= 1'b1;
            wd_cnt    <= '0;
            state     <= DRAIN;
          end else begin
            mask <= mask | bus.ref_wb_issued;
          end
        end

        // Motion-update launch wins over a simultaneous goto_next_ref.
        DRAIN: begin
          if (mu_fire) begin
            drain_cnt <= '0;
            all_ref   <= 1'b0;
            wd_cnt    <= '0;
            state     <= MU_WAIT;
          end else if (drain_end || bus.goto_next_ref) begin
            mask      <= '0;
            drain_cnt <= '0;
            all_ref   <= 1'b0;
            wd_cnt    <= '0;
            state     <= COLLECT;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_WIDTH'(1);
          end
        end

        MU_WAIT: begin
          if (bus.mu_done) begin
            iter_count <= iter_next;
            wd_cnt     <= '0;
            if (iter_next == target) begin
              state <= DONE;
            end else begin
              mask       <= '0;
              iter_start <= 1'b1;
              state      <= COLLECT;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.iter_start          = iter_start;
  assign bus.all_ref_wb_issued   = all_ref;
  assign bus.interconnect_empty  = drain_end;
  assign bus.motion_update_start = mu_fire;
  assign bus.iter_count          = iter_count;
  assign bus.busy                = (state != IDLE) && (state != DONE);
  assign bus.done                = (state == DONE);
  assign bus.timeout_err         = timeout_err;

endmodule

// File: tb/tb_rl_iteration_sequencer.sv
// Self-checking bench for rl_iteration_sequencer with NUM_CELLS=4 and a short
// watchdog. A per-cycle vector table covers one basic iteration, hand-written
// sequences cover drain-window corner cases, the watchdog and async reset, and
// randomized runs are checked against an iteration-level model of the protocol.
module tb_rl_iteration_sequencer;

  localparam int NUM_CELLS      = 4;
  localparam int ITER_WIDTH     = 16;
  localparam int DRAIN_WIDTH    = 3;
  localparam int TIMEOUT_CYCLES = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rl_iteration_sequencer_if #(
    .NUM_CELLS  (NUM_CELLS),
    .ITER_WIDTH (ITER_WIDTH),
    .DRAIN_WIDTH(DRAIN_WIDTH)
  ) bus ();

  rl_iteration_sequencer #(
    .NUM_CELLS     (NUM_CELLS),
    .ITER_WIDTH    (ITER_WIDTH),
    .DRAIN_WIDTH   (DRAIN_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 2000000");
    $fatal(1, "[TB] simulation time limit");
  end

  typedef struct {
    logic                   start;
    logic [ITER_WIDTH-1:0]  n;
    logic [DRAIN_WIDTH-1:0] d;
    logic [NUM_CELLS-1:0]   wb;
    logic                   mu;
    logic                   e_iter_start;
    logic                   e_all_ref;
    logic                   e_ic;
    logic                   e_mus;
    logic                   e_busy;
    logic                   e_done;
    logic [ITER_WIDTH-1:0]  e_count;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic s, logic [NUM_CELLS-1:0] wb, logic mu,
                              logic eis, logic ear, logic eic, logic emus,
                              logic ebusy, logic edone, logic [ITER_WIDTH-1:0] ecnt);
    vec_t v;
    v.start = s; v.n = 16'd1; v.d = 3'd0; v.wb = wb; v.mu = mu;
    v.e_iter_start = eis; v.e_all_ref = ear; v.e_ic = eic; v.e_mus = emus;
    v.e_busy = ebusy; v.e_done = edone; v.e_count = ecnt;
    return v;
  endfunction

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic check_val(input string name, input logic [ITER_WIDTH-1:0] actual,
                           input logic [ITER_WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.start            = 1'b0;
    bus.ref_wb_issued    = '0;
    bus.goto_next_ref    = 1'b0;
    bus.all_reading_done = 1'b1;
    bus.force_path_idle  = 1'b1;
    bus.mu_done          = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, " iter_start"}, bus.iter_start, 1'b0);
    check_bit({tag, " all_ref"}, bus.all_ref_wb_issued, 1'b0);
    check_bit({tag, " interconnect_empty"}, bus.interconnect_empty, 1'b0);
    check_bit({tag, " mu_start"}, bus.motion_update_start, 1'b0);
    check_val({tag, " iter_count"}, bus.iter_count, 16'd0);
    check_bit({tag, " busy"}, bus.busy, 1'b0);
    check_bit({tag, " done"}, bus.done, 1'b0);
    check_bit({tag, " timeout_err"}, bus.timeout_err, 1'b0);
  endtask

  task automatic start_run(input logic [ITER_WIDTH-1:0] n, input logic [DRAIN_WIDTH-1:0] d);
    set_idle();
    bus.start          = 1'b1;
    bus.num_iterations = n;
    bus.drain_cycles   = d;
    next_cycle();
    set_idle();
  endtask

  // Fill the whole mask in one cycle; returns in the first DRAIN cycle.
  task automatic fill_and_enter();
    bus.ref_wb_issued = 4'hF;
    next_cycle();
    set_idle();
    next_cycle();
  endtask

  task automatic finish_iteration(input string tag, input logic [ITER_WIDTH-1:0] count);
    set_idle();
    bus.mu_done = 1'b1;
    #1;
    check_bit({tag, " mu_wait busy"}, bus.busy, 1'b1);
    next_cycle();
    set_idle();
    #1;
    check_bit({tag, " done"}, bus.done, 1'b1);
    check_bit({tag, " busy after done"}, bus.busy, 1'b0);
    check_val({tag, " iter_count"}, bus.iter_count, count);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 14; i++) begin
      set_idle();
      bus.start          = vecs[i].start;
      bus.num_iterations = vecs[i].n;
      bus.drain_cycles   = vecs[i].d;
      bus.ref_wb_issued  = vecs[i].wb;
      bus.mu_done        = vecs[i].mu;
      #1;
      checkOutput(i);
      next_cycle();
    end
  endtask

  task automatic checkOutput(input int i);
    check_bit($sformatf("vec%0d iter_start", i), bus.iter_start, vecs[i].e_iter_start);
    check_bit($sformatf("vec%0d all_ref", i), bus.all_ref_wb_issued, vecs[i].e_all_ref);
    check_bit($sformatf("vec%0d interconnect_empty", i), bus.interconnect_empty, vecs[i].e_ic);
    check_bit($sformatf("vec%0d mu_start", i), bus.motion_update_start, vecs[i].e_mus);
    check_bit($sformatf("vec%0d busy", i), bus.busy, vecs[i].e_busy);
    check_bit($sformatf("vec%0d done", i), bus.done, vecs[i].e_done);
    check_val($sformatf("vec%0d iter_count", i), bus.iter_count, vecs[i].e_count);
  endtask

  // Iteration-level reference: per iteration the bench keeps the set of PEs
  // seen so far; once all are seen, one settling cycle passes, then the drain
  // window of drain_len+1 cycles runs and ends in a motion update only if the
  // idle inputs hold on its last cycle. Any abort restarts collection empty.
  task automatic run_random(input logic [ITER_WIDTH-1:0] n_req, input logic [DRAIN_WIDTH-1:0] d_req);
    int target, dlen, cyc, w;
    logic [NUM_CELLS-1:0] seen, wb;
    logic first, ok, rd_v, fpi_v, gnr_v;
    target = (n_req == 16'd0) ? 1 : int'(n_req);
    dlen   = (d_req == 3'd0) ? NUM_CELLS : int'(d_req);
    set_idle();
    bus.start          = 1'b1;
    bus.num_iterations = n_req;
    bus.drain_cycles   = d_req;
    #1;
    check_bit("rand start busy", bus.busy, 1'b0);
    next_cycle();
    first = 1'b1;
    for (int it = 0; it < target; it++) begin
      ok = 1'b0;
      while (!ok) begin
        seen = '0;
        cyc  = 0;
        while (seen != 4'hF) begin
          wb = (cyc >= 8) ? 4'hF : 4'($urandom);
          set_idle();
          bus.ref_wb_issued  = wb;
          bus.start          = ($urandom_range(7) == 0);
          bus.mu_done        = ($urandom_range(7) == 0);
          bus.num_iterations = 16'($urandom);
          #1;
          check_bit("rand collect iter_start", bus.iter_start, first);
          check_bit("rand collect all_ref", bus.all_ref_wb_issued, 1'b0);
          check_bit("rand collect busy", bus.busy, 1'b1);
          check_bit("rand collect done", bus.done, 1'b0);
          check_val("rand collect iter_count", bus.iter_count, 16'(it));
          first = 1'b0;
          seen  = seen | wb;
          cyc++;
          next_cycle();
        end
        set_idle();
        bus.ref_wb_issued = 4'($urandom);
        #1;
        check_bit("rand settle all_ref", bus.all_ref_wb_issued, 1'b0);
        check_bit("rand settle iter_start", bus.iter_start, 1'b0);
        next_cycle();
        for (int k = 0; k <= dlen; k++) begin
          set_idle();
          bus.ref_wb_issued    = 4'($urandom);
          gnr_v                = (k < dlen) ? ($urandom_range(9) == 0) : ($urandom_range(1) == 1);
          rd_v                 = ($urandom_range(3) != 0);
          fpi_v                = ($urandom_range(3) != 0);
          bus.goto_next_ref    = gnr_v;
          bus.all_reading_done = rd_v;
          bus.force_path_idle  = fpi_v;
          bus.mu_done          = ($urandom_range(7) == 0);
          #1;
          check_bit("rand drain all_ref", bus.all_ref_wb_issued, 1'b1);
          check_bit("rand drain interconnect_empty", bus.interconnect_empty, (k == dlen));
          check_bit("rand drain mu_start", bus.motion_update_start, (k == dlen) && rd_v && fpi_v);
          check_bit("rand drain busy", bus.busy, 1'b1);
          next_cycle();
          if (k == dlen) begin
            ok = rd_v && fpi_v;
            break;
          end
          if (gnr_v) break;
        end
      end
      w = $urandom_range(2);
      for (int j = 0; j < w; j++) begin
        set_idle();
        bus.start         = ($urandom_range(1) == 1);
        bus.goto_next_ref = ($urandom_range(1) == 1);
        #1;
        check_bit("rand mu_wait busy", bus.busy, 1'b1);
        check_bit("rand mu_wait all_ref", bus.all_ref_wb_issued, 1'b0);
        check_bit("rand mu_wait iter_start", bus.iter_start, 1'b0);
        check_bit("rand mu_wait mu_start", bus.motion_update_start, 1'b0);
        check_val("rand mu_wait iter_count", bus.iter_count, 16'(it));
        next_cycle();
      end
      set_idle();
      bus.mu_done = 1'b1;
      #1;
      check_bit("rand mu_done busy", bus.busy, 1'b1);
      next_cycle();
      first = 1'b1;
    end
    set_idle();
    #1;
    check_bit("rand end done", bus.done, 1'b1);
    check_bit("rand end busy", bus.busy, 1'b0);
    check_bit("rand end iter_start", bus.iter_start, 1'b0);
    check_bit("rand end timeout_err", bus.timeout_err, 1'b0);
    check_val("rand end iter_count", bus.iter_count, 16'(target));
    next_cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    set_idle();
    bus.num_iterations = 16'd1;
    bus.drain_cycles   = 3'd0;

    // Basic iteration: bits 0..3 on separate cycles, drain window NUM_CELLS.
    vecs[0]  = mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    vecs[1]  = mk(1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    vecs[2]  = mk(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    vecs[3]  = mk(1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    vecs[4]  = mk(1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    vecs[5]  = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    vecs[6]  = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    vecs[7]  = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    vecs[8]  = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    vecs[9]  = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    vecs[10] = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
    vecs[11] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    vecs[12] = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
    vecs[13] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1);

    next_cycle();
    next_cycle();
    check_all_zero("reset");
    rst = 1'b1;
    next_cycle();

    applyStimulus();

    // drain_cycles=7: interconnect_empty and the MU pulse only on the 8th DRAIN cycle.
    start_run(16'd1, 3'd7);
    fill_and_enter();
    for (int k = 0; k <= 7; k++) begin
      set_idle();
      #1;
      check_bit($sformatf("drain7 k%0d interconnect_empty", k), bus.interconnect_empty, (k == 7));
      check_bit($sformatf("drain7 k%0d mu_start", k), bus.motion_update_start, (k == 7));
      next_cycle();
    end
    finish_iteration("drain7", 16'd1);

    // Force path busy at drain end: back to COLLECT with an empty mask.
    start_run(16'd1, 3'd2);
    fill_and_enter();
    for (int k = 0; k <= 2; k++) begin
      set_idle();
      bus.force_path_idle = 1'b0;
      #1;
      check_bit($sformatf("fpbusy k%0d interconnect_empty", k), bus.interconnect_empty, (k == 2));
      check_bit($sformatf("fpbusy k%0d mu_start", k), bus.motion_update_start, 1'b0);
      next_cycle();
    end
    set_idle();
    bus.ref_wb_issued = 4'h7;
    #1;
    check_bit("fpbusy refill1 all_ref", bus.all_ref_wb_issued, 1'b0);
    check_bit("fpbusy refill1 busy", bus.busy, 1'b1);
    next_cycle();
    set_idle();
    #1;
    check_bit("fpbusy refill2 all_ref", bus.all_ref_wb_issued, 1'b0);
    next_cycle();
    set_idle();
    bus.ref_wb_issued = 4'h8;
    #1;
    check_bit("fpbusy refill3 all_ref", bus.all_ref_wb_issued, 1'b0);
    next_cycle();
    set_idle();
    next_cycle();
    for (int k = 0; k <= 2; k++) begin
      set_idle();
      #1;
      check_bit($sformatf("fpbusy retry k%0d mu_start", k), bus.motion_update_start, (k == 2));
      next_cycle();
    end
    finish_iteration("fpbusy", 16'd1);

    // goto_next_ref aborts mid-drain but loses to the MU launch at drain end.
    start_run(16'd1, 3'd4);
    fill_and_enter();
    next_cycle();
    next_cycle();
    set_idle();
    bus.goto_next_ref = 1'b1;
    #1;
    check_bit("gnr k2 all_ref", bus.all_ref_wb_issued, 1'b1);
    check_bit("gnr k2 mu_start", bus.motion_update_start, 1'b0);
    next_cycle();
    set_idle();
    #1;
    check_bit("gnr abort all_ref", bus.all_ref_wb_issued, 1'b0);
    check_bit("gnr abort busy", bus.busy, 1'b1);
    fill_and_enter();
    for (int k = 0; k <= 4; k++) begin
      set_idle();
      bus.goto_next_ref = (k == 4);
      #1;
      check_bit($sformatf("gnr end k%0d mu_start", k), bus.motion_update_start, (k == 4));
      next_cycle();
    end
    set_idle();
    bus.start          = 1'b1;
    bus.num_iterations = 16'd5;
    #1;
    check_bit("busy start all_ref", bus.all_ref_wb_issued, 1'b0);
    next_cycle();
    set_idle();
    #1;
    check_bit("busy start ignored iter_start", bus.iter_start, 1'b0);
    check_bit("busy start ignored busy", bus.busy, 1'b1);
    finish_iteration("gnr", 16'd1);

    // Randomized runs, including num_iterations=3 and num_iterations=0.
    run_random(16'd3, 3'd2);
    run_random(16'd0, 3'd5);
    for (int r = 0; r < 12; r++) begin
      run_random(16'($urandom_range(4)), 3'($urandom_range(7)));
    end

    // Watchdog: mask never fills, timeout_err rises after the 16th COLLECT cycle.
    start_run(16'd1, 3'd0);
    for (int i = 0; i < 15; i++) next_cycle();
    check_bit("watchdog before limit", bus.timeout_err, 1'b0);
    next_cycle();
    check_bit("watchdog at limit", bus.timeout_err, 1'b1);
    check_bit("watchdog busy", bus.busy, 1'b1);
    check_bit("watchdog all_ref", bus.all_ref_wb_issued, 1'b0);

    // Async reset in the middle of DRAIN.
    fill_and_enter();
    next_cycle();
    check_bit("pre-reset all_ref", bus.all_ref_wb_issued, 1'b1);
    check_bit("pre-reset timeout_err", bus.timeout_err, 1'b1);
    rst = 1'b0;
    #1;
    check_all_zero("async reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_idle();
    #1;
    check_bit("post-reset iter_start", bus.iter_start, 1'b0);
    check_bit("post-reset busy", bus.busy, 1'b0);
    next_cycle();
    check_bit("post-reset2 iter_start", bus.iter_start, 1'b0);
    check_bit("post-reset2 busy", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
